// File: rtl/pll_reset_sequencer_if.sv
// Bundles the PLL lock / button inputs and SoC reset outputs of the reset sequencer.
`timescale 1ns/1ps
interface pll_reset_sequencer_if;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned LLCNT_W = 8;

  logic               in_locked;
  logic               in_btn_reset_n;
  logic               out_reset;
  logic               out_reset_n;
  logic [STATE_W-1:0] out_state;
  logic [LLCNT_W-1:0] out_lock_loss_cnt;

  modport master (
    output in_locked,
    output in_btn_reset_n,
    input  out_reset,
    input  out_reset_n,
    input  out_state,
    input  out_lock_loss_cnt
  );

  modport slave (
    input  in_locked,
    input  in_btn_reset_n,
    output out_reset,
    output out_reset_n,
    output out_state,
    output out_lock_loss_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Releases the SoC reset only after PLL lock has been stable and a hold time has elapsed.
// Optional lock-loss event counter built when LOCK_LOSS_CNT_EN is defined.
`timescale 1ns/1ps
module pll_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 256
) (
  input  logic                   in_clk80,
  input  logic                   in_reset_n,
  pll_reset_sequencer_if.slave   bus
);
  localparam int unsigned MAX_CYC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                    LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned LLCNT_W = 8;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lock_meta_q, locked_s_q;
  logic               btn_meta_q, btn_s_q;
  logic               out_reset_q, out_reset_n_q;
  logic               ok;

  // Two-flop synchronizers for the asynchronous lock and button inputs
  always_ff @(posedge in_clk80 or negedge in_reset_n) begin
    if (!in_reset_n) begin
      lock_meta_q <= 1'b0;
      locked_s_q  <= 1'b0;
      btn_meta_q  <= 1'b0;
      btn_s_q     <= 1'b0;
    end else begin
      lock_meta_q <= bus.in_locked;
      locked_s_q  <= lock_meta_q;
      btn_meta_q  <= bus.in_btn_reset_n;
      btn_s_q     <= btn_meta_q;
    end
  end

  assign ok = locked_s_q & btn_s_q;

  always_ff @(posedge in_clk80 or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      out_reset_q   <= 1'b1;
      out_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_reset_q   <= (state_d != RUN);
      out_reset_n_q <= (state_d == RUN);
    end
  end

  // Counter is cleared on every state change, so it only advances while staying put
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (ok) state_d = STABLE;
      end
      STABLE: begin
        if (!ok) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!ok) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == CNT_W'(RESET_HOLD_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!ok) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign bus.out_reset   = out_reset_q;
  assign bus.out_reset_n = out_reset_n_q;
  assign bus.out_state   = 2'(state_q);

`ifdef LOCK_LOSS_CNT_EN
  logic [LLCNT_W-1:0] loss_cnt_q;

  // Counts RUN exits caused by lock loss (button-only exits excluded); saturating
  always_ff @(posedge in_clk80 or negedge in_reset_n) begin
    if (!in_reset_n) begin
      loss_cnt_q <= '0;
    end else if ((state_q == RUN) && !locked_s_q && (loss_cnt_q != {LLCNT_W{1'b1}})) begin
      loss_cnt_q <= loss_cnt_q + LLCNT_W'(1);
    end
  end

  assign bus.out_lock_loss_cnt = loss_cnt_q;
`else
  assign bus.out_lock_loss_cnt = '0;
`endif
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected output states are queued per clock edge.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;
  localparam int unsigned L = 16;
  localparam int unsigned H = 8;

  typedef struct {
    int          e;
    logic [1:0]  st;
    logic [7:0]  cnt;
    string       tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  pll_reset_sequencer_if u_if ();

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES (L),
    .RESET_HOLD_CYCLES  (H)
  ) u_dut (
    .in_clk80   (clk),
    .in_reset_n (rst_n),
    .bus        (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got=%0h exp=%0h", tag, edge_cnt, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_cnt(input int events);
`ifdef LOCK_LOSS_CNT_EN
    return (events > 255) ? 8'hFF : 8'(events);
`else
    return 8'h00;
`endif
  endfunction

  task automatic push(input int e, input logic [1:0] st, input logic [7:0] cnt, input string tag);
    exp_t it;
    it.e = e; it.st = st; it.cnt = cnt; it.tag = tag;
    sb.push_back(it);
  endtask

  // Full release sequence when lock/button is first sampled good at edge k
  task automatic push_seq(input int k, input logic [7:0] cnt, input string tag);
    push(k + 1,         2'd0, cnt, {tag, "_wait"});
    push(k + 2,         2'd1, cnt, {tag, "_stable"});
    push(k + 1 + L,     2'd1, cnt, {tag, "_stable_end"});
    push(k + 2 + L,     2'd2, cnt, {tag, "_hold"});
    push(k + 1 + L + H, 2'd2, cnt, {tag, "_hold_end"});
    push(k + 2 + L + H, 2'd3, cnt, {tag, "_run"});
  endtask

  task automatic wait_edge(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  // Compare DUT outputs against every expectation due at this edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].e <= edge_cnt) begin
      exp_t it;
      it = sb.pop_front();
      check_val({it.tag, "_edge"},    32'(edge_cnt),               32'(it.e));
      check_val({it.tag, "_state"},   32'(u_if.out_state),         32'(it.st));
      check_val({it.tag, "_reset"},   32'(u_if.out_reset),         32'(it.st != 2'd3));
      check_val({it.tag, "_reset_n"}, 32'(u_if.out_reset_n),       32'(it.st == 2'd3));
      check_val({it.tag, "_llcnt"},   32'(u_if.out_lock_loss_cnt), 32'(it.cnt));
    end
  end

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_reset"},   32'(u_if.out_reset),         32'd1);
    check_val({tag, "_reset_n"}, 32'(u_if.out_reset_n),       32'd0);
    check_val({tag, "_state"},   32'(u_if.out_state),         32'd0);
    check_val({tag, "_llcnt"},   32'(u_if.out_lock_loss_cnt), 32'd0);
  endtask

  initial begin
    int n, k, kr, s, events;
    rst_n = 1'b0;
    u_if.in_locked = 1'b0;
    u_if.in_btn_reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");

    // Power-up release with lock and button already good
    rst_n = 1'b1;
    u_if.in_locked = 1'b1;
    k = edge_cnt + 1;
    push_seq(k, 8'd0, "boot");
    wait_edge(k + 2 + L + H + 1);
    events = 0;

    // Lock lost for 3 cycles while running
    n = edge_cnt;
    u_if.in_locked = 1'b0;
    k = n + 1;
    kr = n + 4;
    events++;
    push(k + 1, 2'd3, exp_cnt(0), "lol_still_run");
    push(k + 2, 2'd0, exp_cnt(1), "lol_abort");
    push_seq(kr, exp_cnt(1), "lol_reseq");
    repeat (3) @(negedge clk);
    u_if.in_locked = 1'b1;
    wait_edge(kr + 2 + L + H + 1);

    // Button held for 5 cycles while running
    n = edge_cnt;
    u_if.in_btn_reset_n = 1'b0;
    k = n + 1;
    kr = n + 6;
    push(k + 1, 2'd3, exp_cnt(1), "btn_still_run");
    push(k + 2, 2'd0, exp_cnt(1), "btn_abort");
    push_seq(kr, exp_cnt(1), "btn_reseq");
    repeat (5) @(negedge clk);
    u_if.in_btn_reset_n = 1'b1;
    wait_edge(kr + 2 + L + H + 1);

    // One-cycle lock glitch to restart, then another glitch mid-STABLE
    n = edge_cnt;
    u_if.in_locked = 1'b0;
    events++;
    s = n + 4;
    push(n + 2, 2'd3, exp_cnt(1), "g1_still_run");
    push(n + 3, 2'd0, exp_cnt(2), "g1_abort");
    push(s,     2'd1, exp_cnt(2), "g1_stable");
    @(negedge clk);
    u_if.in_locked = 1'b1;
    wait_edge(s + 8);
    u_if.in_locked = 1'b0;
    push(s + 10, 2'd1, exp_cnt(2), "g2_stable_c10");
    push(s + 11, 2'd0, exp_cnt(2), "g2_abort");
    push_seq(s + 10, exp_cnt(2), "g2_reseq");
    @(negedge clk);
    u_if.in_locked = 1'b1;
    wait_edge(s + 12 + L + H + 1);

    // Async reset asserted mid-HOLD
    n = edge_cnt;
    u_if.in_locked = 1'b0;
    events++;
    push(n + 3, 2'd0, exp_cnt(3), "g3_abort");
    push(n + 4 + L, 2'd2, exp_cnt(3), "g3_hold");
    @(negedge clk);
    u_if.in_locked = 1'b1;
    wait_edge(n + 4 + L + 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(negedge clk);
    check_reset_vals("async_rst_held");
    rst_n = 1'b1;
    k = edge_cnt + 1;
    push_seq(k, 8'd0, "rst_reseq");
    wait_edge(k + 2 + L + H + 1);

    // Repeated lock-loss events drive the counter into saturation
    for (int i = 1; i <= 300; i++) begin
      n = edge_cnt;
      u_if.in_locked = 1'b0;
      push(n + 2, 2'd3, exp_cnt(i - 1), "sat_run");
      push(n + 3, 2'd0, exp_cnt(i), "sat_abort");
      push(n + 4 + L + H, 2'd3, exp_cnt(i), "sat_rerun");
      @(negedge clk);
      u_if.in_locked = 1'b1;
      wait_edge(n + 5 + L + H);
    end

    repeat (4) @(negedge clk);
    check_val("sb_leftover", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
